// File: rtl/sha256_msg_sched.sv
// SHA-256 message scheduler: loads one 512-bit block, then streams W_t/K_t for
// rounds 0..63 to the hash core, expanding the schedule in a 16-word ring.
module sha256_msg_sched #(
  parameter int GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        blk_valid_i,
  input  logic [31:0] blk_word_i,
  output logic        blk_ready_o,
  input  logic        abort_i,
  output logic        start_o,
  output logic [31:0] wt_o,
  output logic [31:0] kt_o,
  output logic        rnd_valid_o,
  output logic [5:0]  round_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_ROUNDS,
    S_FINAL
  } state_t;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_buf [16];
  logic [3:0]  r_idx;
  logic [5:0]  r_t;
  logic [3:0]  r_gap;

  logic        w_accept;
  logic        w_gap_last;
  logic [3:0]  w_i1;
  logic [3:0]  w_i9;
  logic [3:0]  w_i14;
  logic [31:0] w_x1;
  logic [31:0] w_x14;
  logic [31:0] w_s0;
  logic [31:0] w_s1;
  logic [31:0] w_sched;

  assign w_accept   = (r_state == S_LOAD) && blk_valid_i && !abort_i;
  assign w_gap_last = (r_gap == GAP_LAST);

  // Ring indices for W[t-15], W[t-7], W[t-2] relative to slot t%16 (= W[t-16]).
  assign w_i1  = r_t[3:0] + 4'd1;
  assign w_i9  = r_t[3:0] + 4'd9;
  assign w_i14 = r_t[3:0] + 4'd14;
  assign w_x1  = r_buf[w_i1];
  assign w_x14 = r_buf[w_i14];

  assign w_s0 = {w_x1[6:0], w_x1[31:7]} ^ {w_x1[17:0], w_x1[31:18]} ^ {3'b000, w_x1[31:3]};
  assign w_s1 = {w_x14[16:0], w_x14[31:17]} ^ {w_x14[18:0], w_x14[31:19]} ^ {10'b0, w_x14[31:10]};

  assign w_sched = (r_t < 6'd16) ? r_buf[r_t[3:0]]
                                 : (w_s1 + r_buf[w_i9] + w_s0 + r_buf[r_t[3:0]]);

  always_comb begin
    w_state_next = r_state;
    blk_ready_o  = 1'b0;
    start_o      = 1'b0;
    rnd_valid_o  = 1'b0;
    done_o       = 1'b0;
    wt_o         = 32'd0;
    kt_o         = 32'd0;
    round_o      = r_t;
    case (r_state)
      S_IDLE: w_state_next = S_LOAD;
      S_LOAD: begin
        blk_ready_o = !abort_i;
        if (w_accept && r_idx == 4'd15) w_state_next = S_START;
      end
      S_START: begin
        start_o      = !abort_i;
        w_state_next = S_ROUNDS;
      end
      S_ROUNDS: begin
        rnd_valid_o = 1'b1;
        wt_o        = w_sched;
        kt_o        = K_ROM[r_t];
        if (r_t == 6'd63) w_state_next = S_FINAL;
      end
      S_FINAL: begin
        done_o = w_gap_last && !abort_i;
        if (w_gap_last) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (abort_i) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
      r_t     <= 6'd0;
      r_gap   <= 4'd0;
      for (int i = 0; i < 16; i++) r_buf[i] <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (abort_i) begin
        r_idx <= 4'd0;
        r_t   <= 6'd0;
        r_gap <= 4'd0;
      end else begin
        case (r_state)
          S_LOAD: begin
            // idx wraps 15 -> 0 on the last word, leaving it cleared for START
            if (w_accept) begin
              r_buf[r_idx] <= blk_word_i;
              r_idx        <= r_idx + 4'd1;
            end
          end
          S_ROUNDS: begin
            r_buf[r_t[3:0]] <= w_sched;
            r_gap           <= 4'd0;
            if (r_t != 6'd63) r_t <= r_t + 6'd1;
          end
          S_FINAL: begin
            if (w_gap_last) begin
              r_gap <= 4'd0;
              r_t   <= 6'd0;
            end else begin
              r_gap <= r_gap + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched: "abc" block, stalls, abort, reset and
// back-to-back period, with schedule words checked against a plain W[] model.
module tb_sha256_msg_sched;

  localparam int GAP = 2;
  localparam int PERIOD = 1 + 16 + 1 + 64 + GAP;

  logic        clk;
  logic        rst_n;
  logic        blk_valid_i;
  logic [31:0] blk_word_i;
  logic        blk_ready_o;
  logic        abort_i;
  logic        start_o;
  logic [31:0] wt_o;
  logic [31:0] kt_o;
  logic        rnd_valid_o;
  logic [5:0]  round_o;
  logic        done_o;

  sha256_msg_sched #(.GAP_CYCLES(GAP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .blk_valid_i (blk_valid_i),
    .blk_word_i  (blk_word_i),
    .blk_ready_o (blk_ready_o),
    .abort_i     (abort_i),
    .start_o     (start_o),
    .wt_o        (wt_o),
    .kt_o        (kt_o),
    .rnd_valid_o (rnd_valid_o),
    .round_o     (round_o),
    .done_o      (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int last_done_cyc = 0;
  logic [31:0] cur_blk [16];
  logic [31:0] obs_w [64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(blk_ready_o), 32'd0);
    chk({tag, "_start"}, 32'(start_o), 32'd0);
    chk({tag, "_wt"}, wt_o, 32'd0);
    chk({tag, "_kt"}, kt_o, 32'd0);
    chk({tag, "_rvalid"}, 32'(rnd_valid_o), 32'd0);
    chk({tag, "_round"}, 32'(round_o), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
  endtask

  // Runs one block from IDLE/LOAD through FINAL. Optional abort at round
  // abort_t, or async reset just before word rst_word would be accepted.
  task automatic run_block(input bit stall, input int abort_t, input int rst_word);
    logic [31:0] w [64];
    int acc;
    int guard;
    for (int i = 0; i < 16; i++) w[i] = cur_blk[i];
    for (int i = 16; i < 64; i++)
      w[i] = ssig1(w[i-2]) + w[i-7] + ssig0(w[i-15]) + w[i-16];

    acc = 0;
    guard = 0;
    while (acc < 16 && guard < 400) begin
      @(negedge clk);
      guard++;
      if (rst_word >= 0 && acc == rst_word && blk_ready_o) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_load");
        @(negedge clk);
        rst_n = 1'b1;
        blk_valid_i = 1'b0;
        $display("blk reset at word %0d cycle %0d", acc, cyc);
        return;
      end
      blk_valid_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      blk_word_i  = blk_valid_i ? cur_blk[acc] : 32'hDEAD_BEEF;
      if (blk_valid_i && blk_ready_o) acc++;
    end
    if (acc < 16) begin
      chk("load_timeout", 32'(acc), 32'd16);
      return;
    end

    @(negedge clk);
    blk_valid_i = 1'b1;
    blk_word_i  = 32'hBAD0_0001;
    chk("start_pulse", 32'(start_o), 32'd1);
    chk("start_ready", 32'(blk_ready_o), 32'd0);

    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      blk_word_i = 32'hBAD0_0000 + 32'(t);
      obs_w[t] = wt_o;
      chk($sformatf("rvalid_t%0d", t), 32'(rnd_valid_o), 32'd1);
      chk($sformatf("round_t%0d", t), 32'(round_o), 32'(t));
      chk($sformatf("wt_t%0d", t), wt_o, w[t]);
      if (t == 0) begin
        chk("start_once", 32'(start_o), 32'd0);
        chk("k0", kt_o, 32'h428a2f98);
      end
      if (t == 63) chk("k63", kt_o, 32'hc67178f2);
      if (t == abort_t) begin
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        blk_valid_i = 1'b0;
        check_reset_outputs("abort");
        $display("blk aborted at t=%0d cycle %0d", t, cyc);
        return;
      end
    end

    for (int g = 0; g < GAP; g++) begin
      @(negedge clk);
      chk("final_rvalid", 32'(rnd_valid_o), 32'd0);
      chk("final_wt", wt_o, 32'd0);
      chk("final_kt", kt_o, 32'd0);
      chk($sformatf("final_done_g%0d", g), 32'(done_o), (g == GAP - 1) ? 32'd1 : 32'd0);
      if (done_o) last_done_cyc = cyc;
    end
    $display("blk done cycle %0d W0=%08h W63=%08h", last_done_cyc, obs_w[0], obs_w[63]);
  endtask

  task automatic random_block();
    for (int i = 0; i < 16; i++) cur_blk[i] = $urandom;
  endtask

  int d1;

  initial begin
    rst_n = 1'b0;
    blk_valid_i = 1'b0;
    blk_word_i = 32'd0;
    abort_i = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // "abc" padded block
    cur_blk[0] = 32'h61626380;
    for (int i = 1; i < 15; i++) cur_blk[i] = 32'd0;
    cur_blk[15] = 32'h00000018;
    run_block(1'b0, -1, -1);
    chk("abc_w16", obs_w[16], 32'h61626380);
    chk("abc_w17", obs_w[17], 32'h000F0000);
    d1 = last_done_cyc;

    // back-to-back with no stalls: done spacing equals the minimum period
    random_block();
    run_block(1'b0, -1, -1);
    chk("period", 32'(last_done_cyc - d1), 32'(PERIOD));

    // random valid stalls during LOAD, junk offered during IDLE/ROUNDS
    random_block();
    run_block(1'b1, -1, -1);

    // abort mid-rounds, then a different block must not see stale data
    random_block();
    run_block(1'b0, 30, -1);
    random_block();
    run_block(1'b0, -1, -1);

    // async reset during LOAD word 9, then a fresh block
    random_block();
    run_block(1'b0, -1, 9);
    random_block();
    run_block(1'b1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
